pad_intr_ctrl: RTL and testbench

Parametrised east-side interrupt pad controller. It sits between the HIO18 pad cells and the core, with one block serving all external interrupt channels. For each channel it synchronises the raw pad input, glitch-filters it and latches it in edge or level mode, then presents it to the core as a pending request. On the return path, a single-cycle core acknowledge is stretched into a fixed-width pulse on the ack output pad, and a registered wake request is raised while the core sleeps.

---
 rtl/pads_pkg.sv | 16 +
 rtl/pad_in_filter.sv | 49 ++++
 rtl/pad_intr_ctrl.sv | 114 +++++++++++
 tb/tb_pad_intr_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pads_pkg.sv
// Shared constants for the east-side interrupt pad controller: default
// geometry, ack-stretcher FSM states and per-channel mode encodings.
package pads_pkg;
  localparam int N_CH_DEF        = 2;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_W_DEF      = 4;
  localparam int ACK_CYC_DEF     = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } ack_state_e;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;
endpackage

// File: rtl/pad_in_filter.sv
// One interrupt channel's input path: multi-flop synchroniser followed by a
// glitch filter that only accepts a level held for cfg_filt_i+1 cycles.
module pad_in_filter
  import pads_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W      = FILT_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_h_i,
  input  logic              pad_i,
  input  logic [FILT_W-1:0] cfg_filt_i,
  output logic              f_o
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_p0;
  logic [FILT_W-1:0]      cnt_p1;
  logic                   f_p1;

  // Stage 0: synchroniser chain, pad enters at bit 0
  always_ff @(posedge clk_i) begin
    if (reset_h_i) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pad_i};
    end
  end

  assign s_p0 = sync_p0[SYNC_STAGES-1];

  // Stage 1: counter runs only while the synchronised level disagrees with f
  always_ff @(posedge clk_i) begin
    if (reset_h_i) begin
      cnt_p1 <= '0;
      f_p1   <= 1'b0;
    end else if (s_p0 == f_p1) begin
      cnt_p1 <= '0;
    end else if (cnt_p1 == cfg_filt_i) begin
      f_p1   <= s_p0;
      cnt_p1 <= '0;
    end else begin
      cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  assign f_o = f_p1;

endmodule

// File: rtl/pad_intr_ctrl.sv
// Interrupt pad controller: per-channel filtered inputs latched into pending
// requests, ack pulses stretched onto the pad, and a registered wake request.
module pad_intr_ctrl
  import pads_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W      = FILT_W_DEF,
  parameter int ACK_CYC     = ACK_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              reset_h_i,
  input  logic [N_CH-1:0]   pad_intr_i,
  input  logic [N_CH-1:0]   cfg_edge_i,
  input  logic [FILT_W-1:0] cfg_filt_i,
  input  logic [N_CH-1:0]   intr_ack_i,
  input  logic              core_sleep_i,
  output logic [N_CH-1:0]   intr_h_o,
  output logic [N_CH-1:0]   pad_ack_o,
  output logic              wake_o
);

  localparam int ACK_W = (ACK_CYC > 1) ? $clog2(ACK_CYC) : 1;
  localparam logic [ACK_W-1:0] ACK_LOAD = ACK_W'(ACK_CYC - 1);

  logic [N_CH-1:0] f;
  logic [N_CH-1:0] pend;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic             f_d_p2;
    logic             pend_p2;
    logic             ack_v;
    ack_state_e       state_q, state_d;
    logic [ACK_W-1:0] acnt_q, acnt_d;

    pad_in_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_filt (
      .clk_i      (clk_i),
      .reset_h_i  (reset_h_i),
      .pad_i      (pad_intr_i[k]),
      .cfg_filt_i (cfg_filt_i),
      .f_o        (f[k])
    );

    // An ack with nothing pending is ignored entirely
    assign ack_v = intr_ack_i[k] & pend_p2;

    // Stage 2: pending request; a fresh edge beats a same-cycle ack, while
    // in level mode the ack wins for one cycle and the level re-asserts next
    always_ff @(posedge clk_i) begin
      if (reset_h_i) begin
        f_d_p2  <= 1'b0;
        pend_p2 <= 1'b0;
      end else begin
        f_d_p2 <= f[k];
        if (cfg_edge_i[k] == MODE_EDGE) begin
          pend_p2 <= (f[k] & ~f_d_p2) | (pend_p2 & ~ack_v);
        end else begin
          pend_p2 <= ~ack_v & (pend_p2 | f[k]);
        end
      end
    end

    assign pend[k] = pend_p2;

    always_ff @(posedge clk_i) begin
      if (reset_h_i) begin
        state_q <= IDLE;
        acnt_q  <= '0;
      end else begin
        state_q <= state_d;
        acnt_q  <= acnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      acnt_d  = acnt_q;
      case (state_q)
        IDLE: begin
          if (ack_v) begin
            state_d = PULSE;
            acnt_d  = ACK_LOAD;
          end
        end
        PULSE: begin
          if (ack_v) begin
            acnt_d = ACK_LOAD;
          end else if (acnt_q == '0) begin
            state_d = IDLE;
          end else begin
            acnt_d = acnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign pad_ack_o[k] = (state_q == PULSE);
  end

  assign intr_h_o = pend;

  always_ff @(posedge clk_i) begin
    if (reset_h_i) begin
      wake_o <= 1'b0;
    end else begin
      wake_o <= core_sleep_i & (|pend);
    end
  end

endmodule

// File: tb/tb_pad_intr_ctrl.sv
// Bench for pad_intr_ctrl: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a behavioural model built from pad history.
module tb_pad_intr_ctrl;
  localparam int N_CH        = 2;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_W      = 4;
  localparam int ACK_CYC     = 4;
  localparam int HL          = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   pad;
  logic [N_CH-1:0]   mode_edge;
  logic [FILT_W-1:0] cfg;
  logic [N_CH-1:0]   ack;
  logic              sleep;
  logic [N_CH-1:0]   intr_h;
  logic [N_CH-1:0]   pad_ack;
  logic              wake;

  always #5 clk = ~clk;

  pad_intr_ctrl #(
    .N_CH        (N_CH),
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W),
    .ACK_CYC     (ACK_CYC)
  ) dut (
    .clk_i        (clk),
    .reset_h_i    (rst),
    .pad_intr_i   (pad),
    .cfg_edge_i   (mode_edge),
    .cfg_filt_i   (cfg),
    .intr_ack_i   (ack),
    .core_sleep_i (sleep),
    .intr_h_o     (intr_h),
    .pad_ack_o    (pad_ack),
    .wake_o       (wake)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: pad and synchronised-level history per channel
  int  mn;
  bit  m_pad [N_CH][HL];
  bit  m_s   [N_CH][HL];
  bit  m_f   [N_CH];
  bit  m_fp  [N_CH];
  bit  m_pend[N_CH];
  int  m_left[N_CH];
  bit  m_wake;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit any_pend;
    bit s;
    bit stable;
    bit ack_v;
    bit new_pend;
    int c;
    if (rst) begin
      mn = 0;
      m_wake = 0;
      for (int k = 0; k < N_CH; k++) begin
        m_f[k] = 0; m_fp[k] = 0; m_pend[k] = 0; m_left[k] = 0;
      end
      return;
    end
    c = int'(cfg);
    any_pend = 0;
    for (int k = 0; k < N_CH; k++) any_pend |= m_pend[k];
    for (int k = 0; k < N_CH; k++) begin
      m_pad[k][mn % HL] = pad[k];
      s = (mn >= SYNC_STAGES) ? m_pad[k][(mn - SYNC_STAGES) % HL] : 1'b0;
      m_s[k][mn % HL] = s;
      // f follows s once s has disagreed with f for c+1 consecutive samples
      stable = (mn >= c);
      if (stable)
        for (int j = 0; j <= c; j++)
          if (m_s[k][(mn - j) % HL] == m_f[k]) stable = 0;
      ack_v = ack[k] && m_pend[k];
      if (mode_edge[k])
        new_pend = (m_f[k] && !m_fp[k]) || (m_pend[k] && !ack_v);
      else
        new_pend = ack_v ? 1'b0 : (m_pend[k] || m_f[k]);
      if (ack_v) m_left[k] = ACK_CYC;
      else if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
      m_fp[k] = m_f[k];
      if (stable) m_f[k] = s;
      m_pend[k] = new_pend;
    end
    m_wake = sleep && any_pend;
    mn++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("intr_h_o", 32'(intr_h), {30'd0, m_pend[1], m_pend[0]});
    chk("pad_ack_o", 32'(pad_ack), {30'd0, m_left[1] > 0, m_left[0] > 0});
    chk("wake_o", 32'(wake), {31'd0, m_wake});
  endtask

  task automatic do_reset(input logic [FILT_W-1:0] c, input logic [N_CH-1:0] me);
    cfg = c;
    mode_edge = me;
    ack = '0;
    rst = 1'b1;
    tick();
    chk("reset_outs", {29'd0, intr_h, pad_ack, wake}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_intr(input int k, input string tag, output int cyc);
    cyc = 0;
    while (intr_h[k] !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    if (intr_h[k] !== 1'b1) chk({tag, "_timeout"}, 32'(intr_h[k]), 32'd1);
  endtask

  task automatic pulse_len(input int k, output int hi);
    hi = 0;
    while (pad_ack[k] === 1'b1 && hi < 20) begin
      hi++;
      tick();
    end
  endtask

  initial begin
    int lat;
    int hi;
    int rises[N_CH];
    logic [N_CH-1:0] prev;
    int hold[N_CH];

    rst = 1'b0; pad = '0; mode_edge = '1; cfg = 4'd3; ack = '0; sleep = 1'b0;
    @(negedge clk);

    // Glitch rejection and filter latency
    do_reset(4'd3, 2'b11);
    repeat (3) tick();
    pad[0] = 1'b1;
    repeat (3) tick();
    pad[0] = 1'b0;
    repeat (12) begin
      tick();
      chk("glitch_rejected", 32'(intr_h[0]), 32'd0);
    end
    pad[0] = 1'b1;
    lat = 0;
    while (intr_h[0] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
      if (lat == 4) pad[0] = 1'b0;
    end
    chk("edge_latency", lat, 7);

    // Edge-mode ack and stretched pad pulse
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;
    chk("ack_clears", 32'(intr_h[0]), 32'd0);
    pulse_len(0, hi);
    chk("pulse_len", hi, ACK_CYC);
    chk("stays_clear", 32'(intr_h[0]), 32'd0);

    // Held-high edge channel, then new edge coinciding with ack
    pad[0] = 1'b1;
    wait_intr(0, "held", lat);
    chk("held_latency", lat, 7);
    pad[0] = 1'b0;
    repeat (10) tick();
    chk("edge_latched", 32'(intr_h[0]), 32'd1);
    pad[0] = 1'b1;
    repeat (6) tick();
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;
    chk("sim_pend_kept", 32'(intr_h[0]), 32'd1);
    chk("sim_pulse", 32'(pad_ack[0]), 32'd1);
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;
    repeat (8) begin
      tick();
      chk("held_no_reassert", 32'(intr_h[0]), 32'd0);
    end

    // Ack with nothing pending
    ack[1] = 1'b1; tick(); ack[1] = 1'b0;
    chk("stray_ack_no_pulse", 32'(pad_ack[1]), 32'd0);
    tick();
    chk("stray_ack_no_pulse2", 32'(pad_ack[1]), 32'd0);

    // Level mode, including ack extension during a pulse
    do_reset(4'd3, 2'b10);
    pad[0] = 1'b1;
    wait_intr(0, "level", lat);
    chk("level_latency", lat, 7);
    repeat (2) tick();
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;
    chk("level_drop", 32'(intr_h[0]), 32'd0);
    tick();
    chk("level_return", 32'(intr_h[0]), 32'd1);
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;
    pulse_len(0, hi);
    chk("extended_pulse", hi, ACK_CYC);
    pad[0] = 1'b0;
    repeat (10) tick();
    chk("level_latched", 32'(intr_h[0]), 32'd1);
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;
    repeat (6) begin
      tick();
      chk("level_gone", 32'(intr_h[0]), 32'd0);
    end

    // Sleep and wake
    do_reset(4'd3, 2'b11);
    sleep = 1'b1;
    pad[1] = 1'b1;
    wait_intr(1, "wake", lat);
    chk("wake_lags", 32'(wake), 32'd0);
    tick();
    chk("wake_rise", 32'(wake), 32'd1);
    sleep = 1'b0;
    repeat (5) begin
      tick();
      chk("wake_awake", 32'(wake), 32'd0);
    end

    // Reset mid-pulse with pads high
    ack[1] = 1'b1; tick(); ack[1] = 1'b0;
    tick();
    chk("mid_pulse", 32'(pad_ack[1]), 32'd1);
    pad = 2'b11;
    do_reset(4'd3, 2'b11);
    rises[0] = 0; rises[1] = 0;
    prev = intr_h;
    repeat (30) begin
      tick();
      for (int k = 0; k < N_CH; k++)
        if (intr_h[k] && !prev[k]) rises[k]++;
      prev = intr_h;
    end
    chk("post_reset_events0", rises[0], 1);
    chk("post_reset_events1", rises[1], 1);

    // Randomized traffic against the model
    for (int seg = 0; seg < 4; seg++) begin
      do_reset(FILT_W'($urandom_range(0, 4)), N_CH'($urandom));
      for (int k = 0; k < N_CH; k++) hold[k] = 1;
      repeat (300) begin
        for (int k = 0; k < N_CH; k++) begin
          hold[k]--;
          if (hold[k] == 0) begin
            pad[k] = ~pad[k];
            hold[k] = $urandom_range(1, 9);
          end
          ack[k] = ($urandom_range(0, 5) == 0);
        end
        if ($urandom_range(0, 19) == 0) sleep = ~sleep;
        tick();
      end
      ack = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
